nn_param_fifo: RTL and testbench
================================

# nn_param_fifo

Parametrised synchronous FIFO that replaces the fixed 8×32 input buffer in the wishbone_nn datapath. It sits between the Wishbone register interface and the NN compute core, decoupling bus writes from core consumption. It adds the following over the fixed buffer:
- independent push and pop strobes, with simultaneous push+pop in one cycle;
- an exact occupancy count and almost-full/almost-empty watermarks;
- a flush input;
- sticky overflow/underflow error flags.

## Interface
Parameters:
- DATA_W, 32, data word width (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AFULL_TH, DEPTH-2, almost_full asserts when count ≥ AFULL_TH
- AEMPTY_TH, 1, almost_empty asserts when count ≤ AEMPTY_TH

Ports (CW = $clog2(DEPTH)+1):
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- ce  in  1  clock enable; when 0, no state change except reset
- flush  in  1  empty the FIFO (synchronous)
- push  in  1  write request
- data_i  in  DATA_W  write data
- pop  in  1  read request; consumes the head word
- data_o  out  DATA_W  head word (first-word fall-through); 0 when empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  CW  occupancy, 0..DEPTH
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected
- err_clr  in  1  clears overflow/underflow

## Operation
- **Storage:** DEPTH×DATA_W register array with write pointer wp and read pointer rp, each CW-1 bits. Pointers wrap naturally mod DEPTH. count is held in its own CW-bit register, not derived from the pointers, so full and empty are never ambiguous.
- **Pop acceptance:** pop_ok = ce & pop & ~empty.
- **Push acceptance:** push_ok = ce & push & (~full | pop_ok).
  - Push onto a full FIFO is accepted only when a pop is accepted in the same cycle.
  - Pop from an empty FIFO is never accepted, even with a simultaneous push; there is no bypass.
- **Per accepted operation:**
  - push_ok: mem[wp] ← data_i, wp ← wp+1.
  - pop_ok: rp ← rp+1.
  - count ← count + push_ok − pop_ok.
- **Errors:**
  - ce & push & ~push_ok sets overflow.
  - ce & pop & empty sets underflow.
  - err_clr clears both flags. If a clear and a new error occur in the same cycle, the set wins.
- **Flush:** ce & flush sets wp, rp and count to 0 and overrides push/pop in that cycle. Memory contents are not cleared. Error flags are unaffected.
- **ce = 0:** push, pop, flush and err_clr are all ignored. Outputs keep reflecting current state.
- **data_o:** mem[rp] when ~empty, else 0. It is combinational from registered state.
- **Flags:** full, empty, almost_full and almost_empty are combinational from count only.

## Timing
- **Reset:** rst_n low at a rising edge sets wp=0, rp=0, count=0, overflow=0, underflow=0. Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=(AFULL_TH==0), data_o=0. Reset has priority over ce, flush and all requests. Reset in the middle of a burst discards all contents.
- **Write-to-read latency:** one cycle. A word pushed at edge N appears on data_o and is counted in count after edge N.
- **Pop update:** after a pop at edge N, data_o shows the next word (or 0) after edge N.
- **Flag update:** all flags and count update on the same edge as the operation causing them. No output lags state.
- **Wrap-around:** pushes and pops continue seamlessly across pointer wrap. A full FIFO has wp == rp with count == DEPTH.

## Structure
- **Package nn_fifo_pkg:**
  - function clog2_depth;
  - localparam defaults for DATA_W and DEPTH;
  - a parameter-legality check (DEPTH a power of two, thresholds ≤ DEPTH), which fires $error at elaboration.
- **Sub-module nn_fifo_mem:**
  - synchronous-write, asynchronous-read register array;
  - ports: clk, we, waddr, wdata, raddr, rdata.
- **Top level** holds pointers, count, flags and error logic.

## Test plan
- **Reset and defaults:** DEPTH=8, DATA_W=32. Hold rst_n=0 for 2 cycles, then release → count=0, empty=1, almost_empty=1, full=0, data_o=0, overflow=underflow=0.
- **Fill and drain:** push 0x100..0x107 on 8 consecutive cycles → full=1, count=8; almost_full set from count=6. A 9th push → overflow=1, count stays 8. Pop 8 times → data_o sequence 0x100..0x107, then empty=1. A further pop → underflow=1.
- **Simultaneous push+pop:**
  - At count=8: push 0xAA with pop → count stays 8, no overflow; 0xAA emerges 8 pops later.
  - At count=0: push+pop → count=1, underflow=1, data_o=0xAA.
- **Wrap-around:** run 20 cycles of alternating push/pop bursts of 3 with an incrementing pattern → output order preserved, count matches a scoreboard every cycle.
- **Flush and err_clr:** fill 5 words, set overflow, then assert flush → count=0, empty=1, overflow still 1. Assert err_clr together with an underflow-causing pop → underflow=1. Assert err_clr alone → both flags 0.
- **ce gating and reset mid-operation:** with ce=0, push/pop/flush for 4 cycles → no change. Drive rst_n=0 while count=4 with push=1 → count=0 next cycle, pushed word discarded.

Source files
------------

// File: rtl/nn_fifo_pkg.sv
// Shared definitions for the parametrised NN input FIFO: default sizes,
// pointer-width helper and the parameter legality check used at elaboration.
package nn_fifo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 8;

    // Number of address bits needed to index 'depth' entries.
    function automatic int clog2_depth(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) w = i + 1;
        end
        return w;
    endfunction

    // DEPTH must be a power of two (>= 2) and both watermarks must lie in 0..DEPTH.
    function automatic bit params_legal(input int depth, input int afull_th,
                                        input int aempty_th);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (afull_th >= 0) && (afull_th <= depth) &&
               (aempty_th >= 0) && (aempty_th <= depth);
    endfunction

endpackage

// File: rtl/nn_fifo_mem.sv
// Register-array storage for the NN FIFO: synchronous write, asynchronous read.
module nn_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: one word per enabled edge, no reset on contents.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nn_param_fifo.sv
// Parametrised synchronous FIFO between the Wishbone register block and the
// NN compute core. Holds pointers, an explicit occupancy counter, watermark
// flags and sticky overflow/underflow error flags.
module nn_param_fifo
    import nn_fifo_pkg::*;
#(
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int AFULL_TH  = DEPTH - 2,
    parameter  int AEMPTY_TH = 1,
    localparam int AW        = clog2_depth(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop,
    output logic [DATA_W-1:0] data_o,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    if (!params_legal(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
        $error("nn_param_fifo: DEPTH must be a power of two >= 2 and thresholds <= DEPTH");
    end

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic [DATA_W-1:0] rd_data;
    logic              pop_ok;
    logic              push_ok;
    logic              mem_we;
    logic              set_ovf;
    logic              set_udf;

    // Pop never bypasses: an empty FIFO rejects pops even with a push in flight.
    assign pop_ok  = ce & pop & ~empty;
    // A full FIFO still takes a push when the head is leaving in the same cycle.
    assign push_ok = ce & push & (~full | pop_ok);
    assign set_ovf = ce & push & ~push_ok;
    assign set_udf = ce & pop & empty;
    // Flush and reset both discard the write so stale data never lands mid-clear.
    assign mem_we  = push_ok & ~flush & rst_n;

    nn_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wp),
        .wdata (data_i),
        .raddr (rp),
        .rdata (rd_data)
    );

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);
    assign data_o       = empty ? '0 : rd_data;

    // Pointer and occupancy update; flush overrides any push/pop in its cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (ce) begin
            if (flush) begin
                wp    <= '0;
                rp    <= '0;
                count <= '0;
            end else begin
                if (push_ok) wp <= wp + AW'(1);
                if (pop_ok)  rp <= rp + AW'(1);
                count <= count + CW'(push_ok) - CW'(pop_ok);
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (ce) begin
            if (set_ovf)      overflow <= 1'b1;
            else if (err_clr) overflow <= 1'b0;
            if (set_udf)      underflow <= 1'b1;
            else if (err_clr) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nn_param_fifo.sv
// Directed bench for nn_param_fifo (DEPTH=8, DATA_W=32): a table of
// single-cycle vectors for fill/drain, then hand sequences for the
// multi-cycle corner cases.
module tb_nn_param_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        flush;
    logic        push;
    logic [31:0] data_i;
    logic        pop;
    logic [31:0] data_o;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;
    logic        err_clr;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    nn_param_fifo #(.DATA_W(32), .DEPTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .flush        (flush),
        .push         (push),
        .data_i       (data_i),
        .pop          (pop),
        .data_o       (data_o),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    typedef struct {
        logic        push;
        logic        pop;
        logic        clr;
        logic [31:0] din;
        logic [3:0]  cnt;
        logic [31:0] dout;
        logic        full;
        logic        empty;
        logic        afull;
        logic        aempty;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ps, input logic pp, input logic cl,
                                input logic [31:0] din, input logic [3:0] cnt,
                                input logic [31:0] dout, input logic fu, input logic em,
                                input logic af, input logic ae, input logic ov,
                                input logic uf);
        vec_t v;
        v.push = ps; v.pop = pp; v.clr = cl; v.din = din; v.cnt = cnt; v.dout = dout;
        v.full = fu; v.empty = em; v.afull = af; v.aempty = ae; v.ovf = ov; v.udf = uf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Apply currently driven inputs at the next rising edge, then settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 0; pop = 0; flush = 0; err_clr = 0; ce = 1;
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] cnt, input logic [31:0] dout,
                             input logic fu, input logic em, input logic af, input logic ae,
                             input logic ov, input logic uf);
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".data_o"}, data_o, dout);
        chk({tag, ".full"}, 32'(full), 32'(fu));
        chk({tag, ".empty"}, 32'(empty), 32'(em));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
        chk({tag, ".underflow"}, 32'(underflow), 32'(uf));
    endtask

    logic [31:0] sb[$];
    logic [31:0] pat;
    logic [31:0] exp_d;

    initial begin
        //         push pop clr din        cnt dout       fu em af ae ov uf
        vecs.push_back(mk(1, 0, 0, 32'h100, 1, 32'h100, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h101, 2, 32'h100, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h102, 3, 32'h100, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h103, 4, 32'h100, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h104, 5, 32'h100, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h105, 6, 32'h100, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h106, 7, 32'h100, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h107, 8, 32'h100, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h108, 8, 32'h100, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   7, 32'h101, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   6, 32'h102, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   5, 32'h103, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   4, 32'h104, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   3, 32'h105, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   2, 32'h106, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   1, 32'h107, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   0, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   0, 1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 1, 32'h0,   0, 32'h0,   0, 1, 0, 1, 0, 0));

        // Reset held for two cycles
        idle();
        data_i = 32'h0;
        rst_n = 0;
        step(); step();
        rst_n = 1;
        step();
        chk_flags("reset", 0, 32'h0, 0, 1, 0, 1, 0, 0);

        // Fill, overflow, drain, underflow, clear
        for (int i = 0; i < vecs.size(); i++) begin
            push = vecs[i].push; pop = vecs[i].pop; err_clr = vecs[i].clr;
            data_i = vecs[i].din;
            step();
            chk_flags($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].full,
                      vecs[i].empty, vecs[i].afull, vecs[i].aempty, vecs[i].ovf, vecs[i].udf);
        end
        idle();

        // Push+pop on a full FIFO: accepted, count holds, no overflow
        for (int i = 0; i < 8; i++) begin
            push = 1; data_i = 32'h200 + i;
            step();
        end
        push = 1; pop = 1; data_i = 32'hAA;
        step();
        chk_flags("pp_full", 8, 32'h201, 1, 0, 1, 0, 0, 0);
        push = 0;
        for (int i = 0; i < 7; i++) begin
            chk("pp_full.order", data_o, 32'h201 + i);
            step();
        end
        chk("pp_full.aa_head", data_o, 32'hAA);
        chk("pp_full.aa_count", 32'(count), 32'd1);
        step();
        chk("pp_full.drained", 32'(empty), 32'd1);
        idle();

        // Push+pop on an empty FIFO: no bypass, pop is an underflow
        push = 1; pop = 1; data_i = 32'hAA;
        step();
        chk_flags("pp_empty", 1, 32'hAA, 0, 0, 0, 1, 0, 1);
        idle();
        err_clr = 1; pop = 1;
        step();
        chk("pp_empty.pop_clr_count", 32'(count), 32'd0);
        chk("pp_empty.pop_clr_udf", 32'(underflow), 32'd0);
        idle();

        // Wrap-around: alternating bursts of 3 pushes and 3 pops vs a scoreboard
        pat = 32'h300;
        for (int c = 0; c < 20; c++) begin
            if (((c / 3) % 2) == 0) begin
                push = 1; pop = 0; data_i = pat;
                if (sb.size() < 8) sb.push_back(pat);
                pat++;
            end else begin
                push = 0; pop = 1;
                if (sb.size() > 0) void'(sb.pop_front());
            end
            step();
            exp_d = (sb.size() > 0) ? sb[0] : 32'h0;
            chk($sformatf("wrap%0d.count", c), 32'(count), 32'(sb.size()));
            chk($sformatf("wrap%0d.data_o", c), data_o, exp_d);
        end
        idle();

        // Flush keeps sticky errors; err_clr loses to a same-cycle underflow
        flush = 1;
        step();
        flush = 0;
        chk("flush0.count", 32'(count), 32'd0);
        for (int i = 0; i < 9; i++) begin
            push = 1; data_i = 32'h400 + i;
            step();
        end
        push = 0; pop = 1;
        step(); step(); step();
        pop = 0;
        chk("flush.pre_count", 32'(count), 32'd5);
        chk("flush.pre_ovf", 32'(overflow), 32'd1);
        flush = 1;
        step();
        flush = 0;
        chk_flags("flush", 0, 32'h0, 0, 1, 0, 1, 1, 0);
        err_clr = 1; pop = 1;
        step();
        chk("clr_udf.underflow", 32'(underflow), 32'd1);
        chk("clr_udf.overflow", 32'(overflow), 32'd0);
        pop = 0;
        step();
        chk("clr_alone.underflow", 32'(underflow), 32'd0);
        chk("clr_alone.overflow", 32'(overflow), 32'd0);
        idle();

        // ce gating: nothing changes while ce is low
        for (int i = 0; i < 4; i++) begin
            push = 1; data_i = 32'h500 + i;
            step();
        end
        push = 0;
        ce = 0;
        for (int i = 0; i < 4; i++) begin
            push = 1; pop = (i % 2 == 1); flush = (i == 2); err_clr = (i == 3);
            data_i = 32'h5A0 + i;
            step();
            chk($sformatf("ce_off%0d.count", i), 32'(count), 32'd4);
            chk($sformatf("ce_off%0d.data_o", i), data_o, 32'h500);
        end
        idle();

        // Reset mid-operation with a push pending discards everything
        rst_n = 0; push = 1; data_i = 32'h5FF;
        step();
        chk_flags("rst_mid", 0, 32'h0, 0, 1, 0, 1, 0, 0);
        rst_n = 1; push = 1; data_i = 32'h600;
        step();
        idle();
        chk("rst_mid.new_head", data_o, 32'h600);
        chk("rst_mid.new_count", 32'(count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
